// File: rtl/seg_scan4.sv
// Four-digit common-anode 7-segment scanner. It snapshots the time once per frame and blanks all anodes for a short guard interval at the start of each slot.
// Optional build macro SEG_SCAN4_LZ_BLANK_EN blanks the hour-tens digit when it is zero.
module seg_scan4 #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned GUARD    = 16
) (
    input  logic       CP,
    input  logic       CR,
    input  logic [3:0] HourH,
    input  logic [3:0] HourL,
    input  logic [3:0] MinH,
    input  logic [3:0] MinL,
    input  logic       DotEN,
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic       DP
);

    localparam logic [15:0] CNT_MAX   = 16'(SCAN_DIV - 1);
    localparam logic [15:0] GUARD_LEN = 16'(GUARD);

    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic        tick;

    logic [3:0]  hh_q, hh_d;
    logic [3:0]  hl_q, hl_d;
    logic [3:0]  mh_q, mh_d;
    logic [3:0]  ml_q, ml_d;
    logic        dot_q, dot_d;

    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;

    logic [3:0]  digit;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        idx_d = idx_q;
        if (tick) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // The snapshot loads on the last tick of a frame, so the whole next frame shows one consistent time.
    always_comb begin
        hh_d  = hh_q;
        hl_d  = hl_q;
        mh_d  = mh_q;
        ml_d  = ml_q;
        dot_d = dot_q;
        if (tick && idx_q == 2'd3) begin
            hh_d  = HourH;
            hl_d  = HourL;
            mh_d  = MinH;
            ml_d  = MinL;
            dot_d = DotEN;
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    digit = ml_q;
            2'd1:    digit = mh_q;
            2'd2:    digit = hl_q;
            default: digit = hh_q;
        endcase
    end

    // The segments follow idx even during the guard interval, so they settle before the anode turns on.
    always_comb begin
        seg_d = bcd_to_seg(digit);
        dp_d  = ~(idx_q == 2'd2 && dot_q);
        if (cnt_q < GUARD_LEN) begin
            an_d = '1;
        end else begin
            an_d = ~(4'b0001 << idx_q);
        end
`ifdef SEG_SCAN4_LZ_BLANK_EN
        if (idx_q == 2'd3 && hh_q == 4'd0) begin
            an_d  = '1;
            seg_d = '1;
        end
`endif
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            cnt_q <= '0;
            idx_q <= '0;
            hh_q  <= '0;
            hl_q  <= '0;
            mh_q  <= '0;
            ml_q  <= '0;
            dot_q <= 1'b0;
            an_q  <= '1;
            seg_q <= '1;
            dp_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            hh_q  <= hh_d;
            hl_q  <= hl_d;
            mh_q  <= mh_d;
            ml_q  <= ml_d;
            dot_q <= dot_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;
    assign DP  = dp_q;

endmodule

// File: tb/tb_seg_scan4.sv
// Testbench for seg_scan4. It drives randomized inputs and compares the outputs every cycle against a frame/slot model derived from elapsed cycles.
// It also honours SEG_SCAN4_LZ_BLANK_EN when that macro is defined.
module tb_seg_scan4;

    localparam int unsigned SD  = 8;
    localparam int unsigned GD  = 2;
    localparam int unsigned FRM = 4 * SD;

    logic       CP = 1'b0;
    logic       CR = 1'b1;
    logic [3:0] HourH = '0, HourL = '0, MinH = '0, MinL = '0;
    logic       DotEN = 1'b0;
    logic [3:0] AN;
    logic [6:0] SEG;
    logic       DP;

    int checks = 0;
    int errors = 0;

    seg_scan4 #(.SCAN_DIV(SD), .GUARD(GD)) dut (
        .CP(CP), .CR(CR), .HourH(HourH), .HourL(HourL), .MinH(MinH), .MinL(MinL),
        .DotEN(DotEN), .AN(AN), .SEG(SEG), .DP(DP)
    );

    always #5 CP = ~CP;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tab [16];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
        return tab[d];
    endfunction

    // Model: the elapsed cycles since reset give the slot and its position; each frame shows the inputs taken at the last edge of the previous frame.
    int unsigned n = 0;
    logic [3:0]  shown [4];
    logic        shown_dot;
    logic        mvalid = 1'b0;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;

    always @(posedge CP) begin
        int unsigned slot, pos;
        if (CR) begin
            n = 0;
            shown = '{4'd0, 4'd0, 4'd0, 4'd0};
            shown_dot = 1'b0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            mvalid = 1'b1;
        end else if (mvalid) begin
            slot  = n / SD;
            pos   = n % SD;
            e_seg = seg_of(shown[slot]);
            e_dp  = !(slot == 2 && shown_dot);
            e_an  = (pos < GD) ? 4'hF : 4'hF & ~(4'(1) << slot);
`ifdef SEG_SCAN4_LZ_BLANK_EN
            if (slot == 3 && shown[3] == 4'd0) begin
                e_an = 4'hF; e_seg = 7'h7F;
            end
`endif
            if (n == FRM - 1) begin
                shown = '{MinL, MinH, HourL, HourH};
                shown_dot = DotEN;
            end
            n = (n + 1) % FRM;
        end
    end

    always @(negedge CP) begin
        if (mvalid) begin
            check("model_AN", {28'd0, AN}, {28'd0, e_an});
            check("model_SEG", {25'd0, SEG}, {25'd0, e_seg});
            check("model_DP", {31'd0, DP}, {31'd0, e_dp});
        end
    end

    task automatic cyc(input int k);
        for (int i = 0; i < k; i++) @(posedge CP);
        @(negedge CP);
    endtask

    initial begin
        int lows;
        cyc(2);
        CR = 1'b0;
        cyc(1); check("rst_c1_AN", {28'd0, AN}, 32'hF);
        cyc(1); check("rst_c2_AN", {28'd0, AN}, 32'hF);
        cyc(1); check("c3_AN", {28'd0, AN}, 32'hE);
        check("c3_SEG", {25'd0, SEG}, {25'd0, 7'b1000000});
        check("c3_DP", {31'd0, DP}, 32'd1);

        HourH = 4'd2; HourL = 4'd3; MinH = 4'd5; MinL = 4'd9; DotEN = 1'b1;
        cyc(32); check("f2_an0", {28'd0, AN}, 32'hE); check("f2_seg0", {25'd0, SEG}, {25'd0, 7'b0010000});
        check("f2_dp0", {31'd0, DP}, 32'd1);
        cyc(8);  check("f2_an1", {28'd0, AN}, 32'hD); check("f2_seg1", {25'd0, SEG}, {25'd0, 7'b0010010});
        MinL = 4'd0; HourL = 4'hC;
        cyc(8);  check("f2_an2", {28'd0, AN}, 32'hB); check("f2_seg2_held", {25'd0, SEG}, {25'd0, 7'b0110000});
        check("f2_dp2", {31'd0, DP}, 32'd0);
        cyc(8);  check("f2_an3", {28'd0, AN}, 32'h7); check("f2_seg3", {25'd0, SEG}, {25'd0, 7'b0100100});
        check("f2_dp3", {31'd0, DP}, 32'd1);
        cyc(8);  check("f3_an0", {28'd0, AN}, 32'hE); check("f3_seg0_new", {25'd0, SEG}, {25'd0, 7'b1000000});
        cyc(16); check("f3_an2", {28'd0, AN}, 32'hB); check("f3_seg2_dash", {25'd0, SEG}, {25'd0, 7'b0111111});

        CR = 1'b1;
        cyc(1);
        CR = 1'b0;
        check("mid_rst_AN", {28'd0, AN}, 32'hF);
        check("mid_rst_SEG", {25'd0, SEG}, 32'h7F);
        check("mid_rst_DP", {31'd0, DP}, 32'd1);
        HourH = 4'd0;
        cyc(3); check("rst_resume_AN", {28'd0, AN}, 32'hE);
        check("rst_resume_SEG", {25'd0, SEG}, {25'd0, 7'b1000000});
        cyc(29);
        lows = 0;
        for (int i = 0; i < 32; i++) begin
            cyc(1);
            if (AN[3] == 1'b0) begin
                lows++;
                check("hh0_seg", {25'd0, SEG}, {25'd0, 7'b1000000});
            end
        end
`ifdef SEG_SCAN4_LZ_BLANK_EN
        check("hh0_an3_lows", lows, 0);
`else
        check("hh0_an3_lows", lows, 6);
`endif

        for (int i = 0; i < 900; i++) begin
            @(negedge CP);
            CR = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 4))
                    0: HourH = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                    1: HourL = 4'($urandom_range(0, 15));
                    2: MinH  = 4'($urandom_range(0, 15));
                    3: MinL  = 4'($urandom_range(0, 15));
                    default: DotEN = 1'($urandom_range(0, 1));
                endcase
            end
        end
        CR = 1'b0;
        cyc(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
